// File: rtl/fifo_pkg.sv
// Shared types and Gray-code helpers for the async FIFO read side.
package fifo_pkg;

   localparam int unsigned ADDRSIZEL = 4;

   typedef enum logic {IDLE = 1'b0, BURST = 1'b1} rd_state_e;

   // Helpers work on zero-extended 32-bit values; callers cast down to pointer width.
   function automatic logic [31:0] bin2gray(input logic [31:0] b);
      return b ^ (b >> 1);
   endfunction

   function automatic logic [31:0] gray2bin(input logic [31:0] g);
      logic [31:0] b;
      b = g;
      for (int i = 30; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester after 'last', wrapping circularly.
module rr_arbiter #(
   parameter int unsigned NREQ = 4
) (
   input  logic [NREQ-1:0]         req,
   input  logic [$clog2(NREQ)-1:0] last,
   output logic [NREQ-1:0]         gnt
);

   localparam int unsigned IW = $clog2(NREQ);

   logic [IW-1:0] idx;
   logic          found;

   always_comb begin
      gnt   = '0;
      found = 1'b0;
      idx   = '0;
      for (int i = 1; i <= int'(NREQ); i++) begin
         idx = IW'((int'(last) + i) % int'(NREQ));
         if (!found && req[idx]) begin
            gnt[idx] = 1'b1;
            found    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/fifo_rd_sched.sv
// Async FIFO read-domain controller: read pointer, empty flag, occupancy and
// round-robin burst scheduling of the single read port among NREQ consumers.
module fifo_rd_sched #(
   parameter int unsigned ADDRSIZEL = fifo_pkg::ADDRSIZEL,
   parameter int unsigned NREQ      = 4,
   parameter int unsigned MAXBURST  = 4
) (
   input  logic                      rclk,
   input  logic                      rrst_n,
   input  logic [ADDRSIZEL:0]        rq2_wptr,
   input  logic [NREQ-1:0]           req,
   output logic [NREQ-1:0]           gnt,
   output logic [$clog2(NREQ)-1:0]   gnt_id,
   output logic                      rd_en,
   output logic [ADDRSIZEL-1:0]      raddr,
   output logic [ADDRSIZEL:0]        rptr,
   output logic                      rempty,
   output logic [ADDRSIZEL:0]        rd_count
);

   import fifo_pkg::*;

   localparam int unsigned PW = ADDRSIZEL + 1;
   localparam int unsigned IW = $clog2(NREQ);
   localparam int unsigned BW = (MAXBURST > 1) ? $clog2(MAXBURST) : 1;

   rd_state_e     state_q, state_d;
   logic [PW-1:0] rbin_q, rbin_d;
   logic [PW-1:0] rptr_q, rptr_d;
   logic          rempty_q, rempty_d;
   logic [NREQ-1:0] gnt_q, gnt_d;
   logic [IW-1:0] gnt_id_q, gnt_id_d;
   logic [IW-1:0] rr_last_q, rr_last_d;
   logic [BW-1:0] beat_q, beat_d;
   logic [NREQ-1:0] arb_gnt;
   logic [IW-1:0] arb_id;

   rr_arbiter #(
      .NREQ (NREQ)
   ) u_rr_arbiter (
      .req  (req),
      .last (rr_last_q),
      .gnt  (arb_gnt)
   );

   always_comb begin
      arb_id = '0;
      for (int i = 0; i < int'(NREQ); i++) begin
         if (arb_gnt[i]) arb_id = IW'(i);
      end
   end

   // Reads are gated by the registered empty flag only, so underflow cannot occur.
   assign rd_en    = (state_q == BURST) & req[gnt_id_q] & ~rempty_q;
   assign rbin_d   = rbin_q + PW'(rd_en);
   assign rptr_d   = PW'(bin2gray(32'(rbin_d)));
   assign rempty_d = (rptr_d == rq2_wptr);
   assign rd_count = PW'(gray2bin(32'(rq2_wptr))) - rbin_q;

   always_comb begin
      state_d   = state_q;
      gnt_d     = gnt_q;
      gnt_id_d  = gnt_id_q;
      rr_last_d = rr_last_q;
      beat_d    = beat_q;
      unique case (state_q)
         IDLE: begin
            if ((|req) && !rempty_q) begin
               gnt_d    = arb_gnt;
               gnt_id_d = arb_id;
               beat_d   = '0;
               state_d  = BURST;
            end
         end
         BURST: begin
            if (rd_en) beat_d = beat_q + 1'b1;
            // Burst limit, owner withdrawal and empty all hand the port back.
            if ((rd_en && (beat_q == BW'(MAXBURST - 1))) || !req[gnt_id_q] || rempty_q) begin
               state_d   = IDLE;
               gnt_d     = '0;
               rr_last_d = gnt_id_q;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) begin
         state_q   <= IDLE;
         rbin_q    <= '0;
         rptr_q    <= '0;
         rempty_q  <= 1'b1;
         gnt_q     <= '0;
         gnt_id_q  <= '0;
         rr_last_q <= IW'(NREQ - 1);
         beat_q    <= '0;
      end else begin
         state_q   <= state_d;
         rbin_q    <= rbin_d;
         rptr_q    <= rptr_d;
         rempty_q  <= rempty_d;
         gnt_q     <= gnt_d;
         gnt_id_q  <= gnt_id_d;
         rr_last_q <= rr_last_d;
         beat_q    <= beat_d;
      end
   end

   assign gnt    = gnt_q;
   assign gnt_id = gnt_id_q;
   assign raddr  = rbin_q[ADDRSIZEL-1:0];
   assign rptr   = rptr_q;
   assign rempty = rempty_q;

endmodule

// File: tb/tb_fifo_rd_sched.sv
// Directed bench for fifo_rd_sched with hand-computed expectations.
module tb_fifo_rd_sched;

   logic       rclk;
   logic       rrst_n;
   logic [4:0] rq2_wptr;
   logic [3:0] req;
   logic [3:0] gnt;
   logic [1:0] gnt_id;
   logic       rd_en;
   logic [3:0] raddr;
   logic [4:0] rptr;
   logic       rempty;
   logic [4:0] rd_count;

   int checks = 0;
   int errors = 0;

   fifo_rd_sched #(
      .ADDRSIZEL (4),
      .NREQ      (4),
      .MAXBURST  (4)
   ) dut (
      .rclk     (rclk),
      .rrst_n   (rrst_n),
      .rq2_wptr (rq2_wptr),
      .req      (req),
      .gnt      (gnt),
      .gnt_id   (gnt_id),
      .rd_en    (rd_en),
      .raddr    (raddr),
      .rptr     (rptr),
      .rempty   (rempty),
      .rd_count (rd_count)
   );

   initial rclk = 1'b0;
   always #5 rclk = ~rclk;

   function automatic logic [4:0] g(input int unsigned b);
      logic [4:0] x;
      x = b[4:0];
      return x ^ (x >> 1);
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Waits (bounded) for a read strobe, checks it, then steps past the consuming edge.
   task automatic expect_read(input logic [3:0] addr, input logic [3:0] gexp);
      int n;
      n = 0;
      while (rd_en !== 1'b1 && n < 12) begin
         @(negedge rclk);
         n++;
      end
      check("read_seen", 32'(rd_en), 32'd1);
      if (rd_en === 1'b1) begin
         check("raddr", 32'(raddr), 32'(addr));
         check("gnt", 32'(gnt), 32'(gexp));
      end
      @(negedge rclk);
   endtask

   task automatic do_reset();
      req      = '0;
      rq2_wptr = '0;
      rrst_n   = 1'b0;
      repeat (2) @(negedge rclk);
      rrst_n = 1'b1;
   endtask

   initial begin
      int n;
      rrst_n   = 1'b0;
      req      = '0;
      rq2_wptr = '0;

      // Reset state and no grant while empty
      do_reset();
      check("rst_rempty", 32'(rempty), 32'd1);
      check("rst_rptr", 32'(rptr), 32'd0);
      check("rst_gnt", 32'(gnt), 32'd0);
      check("rst_rd_en", 32'(rd_en), 32'd0);
      check("rst_rd_count", 32'(rd_count), 32'd0);
      req = 4'b1111;
      repeat (4) @(negedge rclk);
      check("empty_no_gnt", 32'(gnt), 32'd0);
      check("empty_no_rd", 32'(rd_en), 32'd0);

      // Single requester, 6 words: burst of 4, gap, burst of 2
      req      = 4'b0001;
      rq2_wptr = g(6);
      for (int a = 0; a < 4; a++) expect_read(4'(a), 4'b0001);
      check("burst_gap_gnt", 32'(gnt), 32'd0);
      check("burst_gap_rd", 32'(rd_en), 32'd0);
      expect_read(4'd4, 4'b0001);
      expect_read(4'd5, 4'b0001);
      check("six_rempty", 32'(rempty), 32'd1);
      check("six_rptr", 32'(rptr), 32'(g(6)));
      check("six_no_rd", 32'(rd_en), 32'd0);
      check("six_count", 32'(rd_count), 32'd0);
      req = '0;
      repeat (2) @(negedge rclk);

      // Four requesters, 16 words: grants 0,1,2,3 x 4 beats
      do_reset();
      req      = 4'b1111;
      rq2_wptr = g(16);
      @(negedge rclk);
      check("full_count", 32'(rd_count), 32'd16);
      check("full_rempty", 32'(rempty), 32'd0);
      for (int gi = 0; gi < 4; gi++) begin
         for (int b = 0; b < 4; b++) begin
            expect_read(4'(gi * 4 + b), 4'(1 << gi));
         end
         check("rr_gap_gnt", 32'(gnt), 32'd0);
      end
      check("drain_rempty", 32'(rempty), 32'd1);
      check("drain_count", 32'(rd_count), 32'd0);

      // Owner 0 drops after 2 beats; re-requesting does not win over 1
      req      = 4'b0011;
      rq2_wptr = g(24);
      expect_read(4'd0, 4'b0001);
      expect_read(4'd1, 4'b0001);
      req = 4'b0010;
      @(negedge rclk);
      check("drop_gnt_clear", 32'(gnt), 32'd0);
      req = 4'b0011;
      expect_read(4'd2, 4'b0010);
      check("drop_next_id", 32'(gnt_id), 32'd1);
      req = '0;
      repeat (3) @(negedge rclk);

      // Pointer wrap: preload 30 reads then 5 more words
      do_reset();
      req      = 4'b0001;
      rq2_wptr = g(30);
      n = 0;
      while (!(rempty === 1'b1 && gnt === 4'b0000 && rptr === g(30)) && n < 300) begin
         @(negedge rclk);
         n++;
      end
      check("preload_rptr", 32'(rptr), 32'(g(30)));
      check("preload_raddr", 32'(raddr), 32'd14);
      rq2_wptr = g(3);
      expect_read(4'd14, 4'b0001);
      check("wrap_rptr31", 32'(rptr), 32'(g(31)));
      expect_read(4'd15, 4'b0001);
      check("wrap_rptr0", 32'(rptr), 32'd0);
      expect_read(4'd0, 4'b0001);
      expect_read(4'd1, 4'b0001);
      expect_read(4'd2, 4'b0001);
      check("wrap_rempty", 32'(rempty), 32'd1);
      check("wrap_rptr3", 32'(rptr), 32'(g(3)));

      // Async reset mid-burst
      rq2_wptr = g(11);
      expect_read(4'd3, 4'b0001);
      check("pre_rst_rd", 32'(rd_en), 32'd1);
      rrst_n = 1'b0;
      #1;
      check("arst_gnt", 32'(gnt), 32'd0);
      check("arst_rd_en", 32'(rd_en), 32'd0);
      check("arst_rptr", 32'(rptr), 32'd0);
      check("arst_rempty", 32'(rempty), 32'd1);
      check("arst_raddr", 32'(raddr), 32'd0);
      check("arst_gnt_id", 32'(gnt_id), 32'd0);
      @(negedge rclk);
      rrst_n = 1'b1;
      @(negedge rclk);
      check("post_rst_no_rd", 32'(rd_en), 32'd0);
      check("post_rst_no_gnt", 32'(gnt), 32'd0);
      expect_read(4'd0, 4'b0001);
      req = '0;
      repeat (2) @(negedge rclk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
